vga_pixel_fetch: RTL
====================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
- REQ-001 Parameter IMG_W, default 128, meaning stored image width in pixels.
- REQ-002 Parameter IMG_H, default 96, meaning stored image height in lines.
- REQ-003 Parameter SCALE, default 5, meaning horizontal and vertical pixel replication factor (128x96 -> 640x480).
- REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-005 Port `clk`: input, 1 bit, system/pixel clock; all logic rising-edge.
- REQ-006 Port `reset`: input, 1 bit, asynchronous active-low reset.
- REQ-007 Port `frame_start`: input, 1 bit, one-cycle pulse before the first active line of a frame, from vgacontroller.
- REQ-008 Port `line_start`: input, 1 bit, one-cycle pulse before the first active pixel of every line.
- REQ-009 Port `pix_en`: input, 1 bit, high on each active-pixel cycle.
- REQ-010 Port `wr_en`: input, 1 bit, image memory write strobe.
- REQ-011 Port `wr_addr`: input, 14 bits, write address {row[6:0],col[6:0]}.
- REQ-012 Port `wr_data`: input, 3 bits, {R,G,B} written.
- REQ-013 Port `rgb_out`: output, 3 bits, {R,G,B} to vgacontroller.
- REQ-014 Port `rgb_valid`: output, 1 bit, rgb_out carries an active pixel.
- REQ-015 Port `fetch_err`: output, 1 bit, sticky overrun flag.

Function
- REQ-016 The block SHALL hold an IMG_W*IMG_H x 3-bit memory with synchronous write (wr_en) and synchronous read.
- REQ-017 The block SHALL keep counters hsub (0..SCALE-1), col (0..IMG_W-1), vsub (0..SCALE-1) and row (0..IMG_H-1).
- REQ-018 On each pix_en: hsub increments; at SCALE-1, hsub wraps to 0 and col increments.
- REQ-019 On line_start: hsub=0 and col=0; vsub/row advance as in REQ-018 (vsub wraps at SCALE-1, row increments), except on the first line_start after frame_start.
- REQ-020 On frame_start: row=0, vsub=0, hsub=0, col=0, and the first-line flag is set.
- REQ-021 frame_start and line_start in the same cycle SHALL act as frame_start only, and SHALL count as the first line.
- REQ-022 Read address SHALL be {row,col}; rgb_out/rgb_valid SHALL appear exactly 1 cycle after the pix_en cycle that sampled that address.
- REQ-023 When rgb_valid=0, rgb_out SHALL be 3'b000 (blanking).
- REQ-024 pix_en with col past IMG_W-1, or row past IMG_H-1, SHALL output 3'b000 with rgb_valid=1 and set fetch_err; counters SHALL saturate.
- REQ-025 fetch_err SHALL clear only on reset or frame_start.
- REQ-026 A same-address read and write in one cycle SHALL return the old data.

Reset
- REQ-027 While reset=0: all counters=0, first-line flag=1, rgb_out=3'b000, rgb_valid=0, fetch_err=0.
- REQ-028 Reset mid-frame SHALL abort immediately; operation resumes at the next frame_start.
- REQ-029 Memory contents SHALL NOT be altered by reset.

Configuration
- REQ-030 Macro TEST_PATTERN_EN: when defined, rgb_out SHALL be col[6:4] (8 vertical colour bars, each 80 screen pixels wide) and memory reads SHALL be ignored; writes are still accepted.
- REQ-031 When TEST_PATTERN_EN is undefined, rgb_out SHALL come from memory per REQ-022.

Verification
- REQ-032 Write addr {7'd0,7'd0}=3'b100 and {7'd0,7'd1}=3'b010; send frame_start, line_start, then 10 pix_en -> 5 cycles of 100 then 5 of 010, each 1 cycle after pix_en.
- REQ-033 Send 5 lines of 640 pix_en, then line_start -> 6th line reads row 1 (addresses 128..).
- REQ-034 Send 641 pix_en in one line -> 641st output 000 with rgb_valid=1, fetch_err=1 until the next frame_start.
- REQ-035 Send frame_start and line_start together, then line_start -> first line and second line both read row 0 (vsub 0, then 1).
- REQ-036 Pull reset low mid-line -> same edge rgb_out=000, rgb_valid=0; memory readback unchanged after the next frame.
- REQ-037 With TEST_PATTERN_EN defined, send 640 pix_en -> colour 000..111 in 80-cycle runs.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Scaled frame-buffer fetch: 128x96x3 image replicated SCALE times in both axes for the VGA controller.
// Optional macro TEST_PATTERN_EN replaces memory data with 8 vertical colour bars.
module vga_pixel_fetch #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 96,
  parameter int unsigned SCALE = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_en,
  input  logic        wr_en,
  input  logic [13:0] wr_addr,
  input  logic [2:0]  wr_data,
  output logic [2:0]  rgb_out,
  output logic        rgb_valid,
  output logic        fetch_err
);

  localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned CW    = $clog2(IMG_W + 1);
  localparam int unsigned RW    = $clog2(IMG_H + 1);
  localparam int unsigned DEPTH = IMG_W * IMG_H;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];

  logic [SW-1:0] hsub, hsub_n, vsub, vsub_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic          first_line, first_line_n;
  logic          active, active_n;
  logic [2:0]    rgb_n;
  logic          valid_n, err_n;

  logic          in_range, take, wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [2:0]    px;

  // col/row count one past the image edge so an overrun is detectable
  assign in_range = (col < CW'(IMG_W)) && (row < RW'(IMG_H));
  assign rd_idx   = in_range ? AW'(32'(row) * IMG_W + 32'(col)) : '0;
  assign wr_idx   = AW'(32'(wr_addr[13:7]) * IMG_W + 32'(wr_addr[6:0]));
  assign wr_ok    = wr_en && (32'(wr_addr[13:7]) < IMG_H);
  assign take     = active && pix_en && !frame_start && !line_start;

`ifdef TEST_PATTERN_EN
  assign px = 3'(col >> 4);
`else
  assign px = mem[rd_idx];
`endif

  // Image store; deliberately not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    hsub_n       = hsub;
    col_n        = col;
    vsub_n       = vsub;
    row_n        = row;
    first_line_n = first_line;
    active_n     = active;
    err_n        = fetch_err;
    rgb_n        = 3'b000;
    valid_n      = 1'b0;

    if (frame_start) begin
      hsub_n       = '0;
      col_n        = '0;
      vsub_n       = '0;
      row_n        = '0;
      first_line_n = !line_start;
      active_n     = 1'b1;
      err_n        = 1'b0;
    end else if (active && line_start) begin
      hsub_n = '0;
      col_n  = '0;
      if (first_line) begin
        first_line_n = 1'b0;
      end else if (vsub == SW'(SCALE - 1)) begin
        vsub_n = '0;
        if (row != RW'(IMG_H)) row_n = row + RW'(1);
      end else begin
        vsub_n = vsub + SW'(1);
      end
    end else if (take) begin
      valid_n = 1'b1;
      if (in_range) rgb_n = px;
      else          err_n = 1'b1;
      if (hsub == SW'(SCALE - 1)) begin
        hsub_n = '0;
        if (col != CW'(IMG_W)) col_n = col + CW'(1);
      end else begin
        hsub_n = hsub + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsub       <= '0;
      col        <= '0;
      vsub       <= '0;
      row        <= '0;
      first_line <= 1'b1;
      active     <= 1'b0;
      rgb_out    <= 3'b000;
      rgb_valid  <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      hsub       <= hsub_n;
      col        <= col_n;
      vsub       <= vsub_n;
      row        <= row_n;
      first_line <= first_line_n;
      active     <= active_n;
      rgb_out    <= rgb_n;
      rgb_valid  <= valid_n;
      fetch_err  <= err_n;
    end
  end

endmodule
